// File: rtl/mult_ctrl_pkg.sv
// Shared types for the multiplier issue/collect controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   MULT_LAT_DEFAULT  clk edges from the mult_rst fall to a valid product
//   MCTL_TAG_W        tag width carried through the operand FIFO
//   mctl_state_e      issue FSM states
//   mult_op_t         one queued operand pair with its tag
package mult_ctrl_pkg;

    localparam int MULT_LAT_DEFAULT = 17;

    // Tag bits stored per FIFO entry; the top-level TAG_W must not exceed this.
    localparam int MCTL_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } mctl_state_e;

    typedef struct packed {
        logic [31:0]           x;
        logic [31:0]           y;
        logic [MCTL_TAG_W-1:0] tag;
    } mult_op_t;

endpackage

// File: rtl/op_fifo2.sv
// Operand FIFO of mult_op_t entries, DEPTH deep (power of 2, >= 2).
// Latency: 1 cycle push-to-visible; rdata is the head entry, read combinationally.
// Backpressure: full_o blocks the producer; push and pop together are both honoured, even when full.
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   push_i/wdata_i  write an entry
//   pop_i           drop the head entry (ignored when empty)
//   rdata_o         head entry
//   full_o/empty_o  occupancy flags
module op_fifo2
    import mult_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [$bits(mult_op_t)-1:0]  wdata_i,
    input  logic                         pop_i,
    output logic [$bits(mult_op_t)-1:0]  rdata_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mult_op_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // When full, a simultaneous pop frees the slot being written this edge.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/collect stage for the sequential radix-4 Booth multiplier: queues operands, launches one multiply at a time.
// Latency: out_valid rises MULT_LAT+3 cycles after operand accept (MULT_LAT+2 after the popping IDLE cycle).
// Backpressure: in_ready = FIFO not full; result held in HOLD until out_ready, no issue until then.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_x/in_y/in_tag   operand pair input handshake
//   mult_x/mult_y                   operands to the multiplier, stable LAUNCH..WAIT
//   mult_rst                        registered multiplier reset/start (low while computing)
//   mult_product                    multiplier product, sampled once at the end of WAIT
//   out_valid/out_ready/out_data/out_tag  result handshake
//   out_fit32                       only when MULT_FIT32_EN is defined: out_data[63:31] all equal
module mult_issue_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int TAG_W    = MCTL_TAG_W,
    parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mult_x,
    output logic [31:0]      mult_y,
    output logic             mult_rst,
    input  logic [63:0]      mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef MULT_FIT32_EN
    ,
    output logic             out_fit32
`endif
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    mctl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        mult_x_q, mult_x_d;
    logic [31:0]        mult_y_q, mult_y_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               mult_rst_q, mult_rst_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               sample;

    mult_op_t           fifo_wdata;
    mult_op_t           fifo_rdata;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;

    always_comb begin
        fifo_wdata     = '0;
        fifo_wdata.x   = in_x;
        fifo_wdata.y   = in_y;
        fifo_wdata.tag = MCTL_TAG_W'(in_tag);
    end

    // in_ready uses the pre-edge count, so it stays low in a full cycle even if IDLE pops.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    op_fifo2 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mult_x_q    <= '0;
            mult_y_q    <= '0;
            tag_q       <= '0;
            mult_rst_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mult_x_q    <= mult_x_d;
            mult_y_q    <= mult_y_d;
            tag_q       <= tag_d;
            mult_rst_q  <= mult_rst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mult_x_d    = mult_x_q;
        mult_y_d    = mult_y_q;
        tag_d       = tag_q;
        mult_rst_d  = mult_rst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        fifo_pop    = 1'b0;
        sample      = 1'b0;

        case (state_q)
            IDLE: begin
                mult_rst_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mult_x_d = fifo_rdata.x;
                    mult_y_d = fifo_rdata.y;
                    tag_d    = TAG_W'(fifo_rdata.tag);
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                // mult_rst is still high this cycle; it falls at this edge.
                mult_rst_d = 1'b0;
                cnt_d      = CNT_W'(MULT_LAT - 1);
                state_d    = WAIT;
            end
            WAIT: begin
                // Counting MULT_LAT-1..0 keeps mult_rst low for exactly MULT_LAT cycles,
                // so the capture edge is the MULT_LAT-th edge after the fall.
                if (cnt_q == '0) begin
                    sample      = 1'b1;
                    out_data_d  = mult_product;
                    out_tag_d   = tag_q;
                    out_valid_d = 1'b1;
                    mult_rst_d  = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mult_x    = mult_x_q;
    assign mult_y    = mult_y_q;
    assign mult_rst  = mult_rst_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

`ifdef MULT_FIT32_EN
    logic fit32_q;

    // Signed-32 fit: bits 63..31 are a pure sign extension.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fit32_q <= 1'b0;
        end else if (sample) begin
            fit32_q <= (&mult_product[63:31]) | ~(|mult_product[63:31]);
        end
    end

    assign out_fit32 = fit32_q;
`endif

endmodule
